// File: rtl/mul_seq_32_if.sv
// ============================================================================
// mul_seq_32_if : request/result bundle between a client and mul_seq_32
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mul_seq_32_if;
    logic        start;
    logic        sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, sign, A, B, input  busy, done, HI, LO);
    modport slave  (input  start, sign, A, B, output busy, done, HI, LO);
endinterface

`default_nettype wire

// File: rtl/mul_seq_32.sv
// ============================================================================
// mul_seq_32 : iterative 32x32->64 shift-add multiplier, one adder pass/cycle
//              Optional signed mode compiled in with macro MUL_SIGNED_EN.
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mul_seq_32 (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mul_seq_32_if.slave bus
);

`ifdef MUL_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_DONE = 3'd4
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    logic [31:0] r_m;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_addend;
    logic [32:0] w_sum;

`ifdef MUL_SIGNED_EN
    logic        r_neg;
    logic        r_sgn;
    logic [63:0] w_fix;

    // Operands are captured as magnitudes; |0x80000000| stays 0x80000000 unsigned.
    assign w_a_mag = (bus.sign && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    assign w_b_mag = (bus.sign && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
    assign w_fix   = ~{r_hi, r_lo} + 64'd1;
`else
    logic        w_unused_sign;

    assign w_unused_sign = bus.sign;
    assign w_a_mag       = bus.A;
    assign w_b_mag       = bus.B;
`endif

    assign w_addend = r_lo[0] ? r_m : 32'd0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_LOAD;
            S_LOAD: w_next = S_CALC;
            S_CALC: begin
                if (r_cnt == 6'd31) begin
`ifdef MUL_SIGNED_EN
                    w_next = r_sgn ? S_FIX : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            S_FIX:  w_next = S_DONE;
`endif
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_busy_nxt = (w_next != S_IDLE) && (w_next != S_DONE);
        w_done_nxt = (w_next == S_DONE);
    end

    // Operands are captured on the accepting edge; LOAD is then a settle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_cnt <= 6'd0;
`ifdef MUL_SIGNED_EN
            r_neg <= 1'b0;
            r_sgn <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_m   <= w_a_mag;
                        r_lo  <= w_b_mag;
                        r_hi  <= 32'd0;
                        r_cnt <= 6'd0;
`ifdef MUL_SIGNED_EN
                        r_sgn <= bus.sign;
                        r_neg <= bus.sign & (bus.A[31] ^ bus.B[31]);
`endif
                    end
                end
                S_CALC: begin
                    r_hi  <= w_sum[32:1];
                    r_lo  <= {w_sum[0], r_lo[31:1]};
                    r_cnt <= r_cnt + 6'd1;
                end
`ifdef MUL_SIGNED_EN
                S_FIX: begin
                    if (r_neg) begin
                        r_hi <= w_fix[63:32];
                        r_lo <= w_fix[31:0];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_32.sv
// ============================================================================
// tb_mul_seq_32 : vector table + scoreboard bench for mul_seq_32
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mul_seq_32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mul_seq_32_if bus ();

    mul_seq_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   errors  = 0;
    int   checks  = 0;
    int   elapsed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        e;
        logic [63:0] p;
        p     = {32'd0, a} * {32'd0, b};
        e.lat = 34;
`ifdef MUL_SIGNED_EN
        if (s) begin
            p     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            e.lat = 35;
        end
`endif
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    // Drives a request accepted on the next rising edge (E0); returns one
    // negedge later with elapsed=1 (the LOAD cycle).
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input exp_t e, input bit hold);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.sign  = s;
        bus.start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        elapsed = 1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        while (!bus.done && elapsed < 200) begin
            @(negedge clk);
            elapsed++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done not seen in %0d cycles, required within 200", name, elapsed);
            sb.delete();
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: done with empty scoreboard, required none", name);
            return;
        end
        e = sb.pop_front();
        check({name, "_HI"},  {32'd0, bus.HI}, {32'd0, e.hi});
        check({name, "_LO"},  {32'd0, bus.LO}, {32'd0, e.lo});
        check({name, "_lat"}, 64'(elapsed),    64'(e.lat));
        @(negedge clk);
        elapsed++;
        check({name, "_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        exp_t e;
        bus.start = 1'b0;
        bus.sign  = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;

        vecs[0] = '{32'd7,        32'd6,        1'b0, 32'h00000000, 32'h0000002A, 34};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 34};
`ifdef MUL_SIGNED_EN
        vecs[2] = '{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 35};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 35};
`else
        vecs[2] = '{32'hFFFFFFFD, 32'd5,        1'b1, 32'h00000004, 32'hFFFFFFF1, 34};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 34};
`endif
        vecs[4] = '{32'd0,        32'h12345678, 1'b0, 32'h00000000, 32'h00000000, 34};
        vecs[5] = '{32'hFFFFFFFD, 32'd5,        1'b0, 32'h00000004, 32'hFFFFFFF1, 34};
        for (int i = 6; i < 10; i++) begin
            vecs[i].a = $urandom;
            vecs[i].b = $urandom;
            vecs[i].s = 1'($urandom_range(0, 1));
            e = model(vecs[i].a, vecs[i].b, vecs[i].s);
            vecs[i].hi  = e.hi;
            vecs[i].lo  = e.lo;
            vecs[i].lat = e.lat;
        end

        // Reset state, held and released
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_HI",   {32'd0, bus.HI},   64'd0);
        check("rst_LO",   {32'd0, bus.LO},   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("post_rst_HI",   {32'd0, bus.HI},   64'd0);

        for (int i = 0; i < 10; i++) begin
            e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.lat = vecs[i].lat;
            launch(vecs[i].a, vecs[i].b, vecs[i].s, e, 1'b0);
            check($sformatf("v%0d_busy", i), {63'd0, bus.busy}, 64'd1);
            wait_done($sformatf("v%0d", i));
            check($sformatf("v%0d_idle", i), {63'd0, bus.busy}, 64'd0);
        end

        // Asynchronous reset during CALC cycle 10
        e = '{32'd0, 32'd42, 34};
        launch(32'd7, 32'd6, 1'b0, e, 1'b0);
        while (elapsed < 11) begin
            @(negedge clk);
            elapsed++;
        end
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        check("arst_HI",   {32'd0, bus.HI},   64'd0);
        check("arst_LO",   {32'd0, bus.LO},   64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Start pulse in CALC cycle 5 must be ignored
        e = '{32'd0, 32'd42, 34};
        launch(32'd7, 32'd6, 1'b0, e, 1'b0);
        bus.A = 32'd100;
        bus.B = 32'd100;
        while (elapsed < 6) begin
            @(negedge clk);
            elapsed++;
        end
        bus.start = 1'b1;
        @(negedge clk);
        elapsed++;
        bus.start = 1'b0;
        wait_done("ignored_start");
        @(negedge clk);
        check("ignored_start_noqueue", {63'd0, bus.busy}, 64'd0);

        // Start held high through done: next op begins the edge after DONE
        e = '{32'd0, 32'd15, 34};
        launch(32'd3, 32'd5, 1'b0, e, 1'b1);
        bus.A = 32'h00010000;
        bus.B = 32'h00010001;
        wait_done("held_first");
        check("held_gap_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        check("held_restart_busy", {63'd0, bus.busy}, 64'd1);
        bus.start = 1'b0;
        elapsed   = 1;
        e = '{32'h00000001, 32'h00010000, 34};
        sb.push_back(e);
        wait_done("held_second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
